t07_mem_responder: RTL and testbench

- Memory-side responder for the CPU memory handler's rwi/busy protocol.
- Accepts fetch, read and write requests encoded on rwi, and holds busy high for a programmable number of wait cycles.
- Performs the access on an internal word-addressed SRAM array, returns read data, then drops busy. The initiator completes on the busy falling edge.
- Sits between the memory handler's address/data muxes and on-chip storage; used as the bench and FPGA memory model.

---
 rtl/t07_mem_responder.sv | 152 +++++++++++++++
 tb/tb_t07_mem_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/t07_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : t07_mem_responder
// Brief   : rwi/busy memory responder over a word-addressed SRAM array.
//           Optional alignment faulting: T07_MEM_RESPONDER_ALIGN_CHECK_EN.
// Rev     : 1.0  initial release
// ============================================================================
module t07_mem_responder #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [1:0]  rwi,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wsel_i,
    output logic [31:0] rdata_o,
    output logic        busy,
    output logic        err_o,
    output logic [1:0]  state_o
);
    localparam int          c_AW         = $clog2(DEPTH);
    localparam logic [32:0] c_SPAN       = 33'(DEPTH) << 2;
    localparam logic [3:0]  c_LAT_M1     = 4'(LATENCY - 1);
    localparam logic [1:0]  c_RWI_IDLE   = 2'b00;
    localparam logic [1:0]  c_RWI_WRITE  = 2'b01;
    localparam logic [31:0] c_FAULT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_UNUSED = 2'd3
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  rwi_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wsel_q;
    logic [31:0] rdata_q;
    logic        busy_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH];

    logic [31:0]     w_off;
    logic [c_AW-1:0] w_idx;
    logic            w_range_fault;
    logic            w_align_fault;
    logic            w_fault;
    logic            w_complete;
    logic            w_mem_we;

    assign w_off         = addr_q - BASE_ADDR;
    assign w_idx         = w_off[c_AW+1:2];
    assign w_range_fault = (addr_q < BASE_ADDR) || ({1'b0, w_off} >= c_SPAN);

`ifdef T07_MEM_RESPONDER_ALIGN_CHECK_EN
    logic       w_contig;
    logic [2:0] w_pop;

    // An empty enable set is treated as contiguous (a no-op write).
    always_comb begin
        w_pop = 3'($countones(wsel_q));
        case (wsel_q)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b0110, 4'b1100, 4'b0111, 4'b1110,
            4'b1111: w_contig = 1'b1;
            default: w_contig = 1'b0;
        endcase
        if (rwi_q == c_RWI_WRITE)
            w_align_fault = !w_contig || (({1'b0, addr_q[1:0]} + w_pop) > 3'd4);
        else
            w_align_fault = (addr_q[1:0] != 2'b00);
    end
`else
    assign w_align_fault = 1'b0;
`endif

    assign w_fault    = w_range_fault | w_align_fault;
    assign w_complete = (state_q == S_ACCESS) && (cnt_q == 4'd0);
    assign w_mem_we   = w_complete && (rwi_q == c_RWI_WRITE) && !w_fault;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rwi_q   <= c_RWI_IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wsel_q  <= 4'd0;
            rdata_q <= 32'd0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rwi != c_RWI_IDLE) begin
                        rwi_q   <= rwi;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        wsel_q  <= wsel_i;
                        cnt_q   <= c_LAT_M1;
                        busy_q  <= 1'b1;
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        if (rwi_q != c_RWI_WRITE)
                            rdata_q <= w_fault ? c_FAULT_DATA : mem_q[w_idx];
                        err_q   <= w_fault;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    // Re-arm only once the initiator releases rwi.
                    if (rwi == c_RWI_IDLE)
                        state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Storage has no reset; byte lanes merge under wsel.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wsel_q[b])
                    mem_q[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;
    assign busy    = busy_q;
    assign err_o   = err_q;
    assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_t07_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_t07_mem_responder
// Brief   : table-driven, scoreboarded bench for t07_mem_responder.
// Rev     : 1.0  initial release
// ============================================================================
module tb_t07_mem_responder;
    localparam int c_LAT = 2;

    logic        clk;
    logic        nrst;
    logic [1:0]  rwi;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  wsel_i;
    logic [31:0] rdata_o;
    logic        busy;
    logic        err_o;
    logic [1:0]  state_o;

    t07_mem_responder #(
        .DEPTH(256), .BASE_ADDR(32'h0000_0000), .LATENCY(c_LAT)
    ) dut (
        .clk(clk), .nrst(nrst), .rwi(rwi), .addr_i(addr_i), .wdata_i(wdata_i),
        .wsel_i(wsel_i), .rdata_o(rdata_o), .busy(busy), .err_o(err_o),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rwi;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wsel;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_rd  = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] r, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [31:0] e, input logic er);
        vec_t v;
        v.rwi = r; v.addr = a; v.wdata = d; v.wsel = s; v.exp_rd = e; v.exp_err = er;
        return v;
    endfunction

    // Drives one request, pushes its expectation, and checks it when busy falls.
    task automatic req(input vec_t v, input bit early_drop);
        exp_t e;
        exp_t got;
        int   g;
        int   n;
        @(negedge clk);
        rwi = v.rwi; addr_i = v.addr; wdata_i = v.wdata; wsel_i = v.wsel;
        e.rd  = (v.rwi == 2'b01) ? last_rd : (v.exp_err ? 32'hDEAD_BEEF : v.exp_rd);
        e.err = v.exp_err;
        sb.push_back(e);
        last_rd = e.rd;
        @(negedge clk);
        g = 0;
        while (!busy && g < 20) begin g++; @(negedge clk); end
        if (early_drop) begin
            rwi = 2'b00; addr_i = 32'h0000_0010; wdata_i = 32'd0; wsel_i = 4'hF;
        end
        n = 0;
        while (busy && n < 40) begin n++; @(negedge clk); end
        chk("busy_cycles", 32'(n), 32'(c_LAT));
        got = sb.pop_front();
        chk("rdata", rdata_o, got.rd);
        chk("err_pulse", 32'(err_o), 32'(got.err));
        chk("state_done", 32'(state_o), 32'd2);
        rwi = 2'b00;
        @(negedge clk);
        chk("err_clear", 32'(err_o), 32'd0);
        chk("state_idle", 32'(state_o), 32'd0);
        chk("rdata_hold", rdata_o, got.rd);
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        logic prev;
        pulses = 0;
        prev   = busy;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy && !prev) pulses++;
            prev = busy;
        end
    endtask

    initial begin
        int   p;
        vec_t v;

        vecs.push_back(mk(2'b01, 32'h10,  32'h0051_3093, 4'hF, 32'h0, 1'b0));
        vecs.push_back(mk(2'b11, 32'h10,  32'h0,         4'h0, 32'h0051_3093, 1'b0));
        vecs.push_back(mk(2'b01, 32'h20,  32'h1122_3344, 4'hF, 32'h0, 1'b0));
        vecs.push_back(mk(2'b01, 32'h20,  32'h0000_00AB, 4'h1, 32'h0, 1'b0));
        vecs.push_back(mk(2'b10, 32'h20,  32'h0,         4'h0, 32'h1122_33AB, 1'b0));
        vecs.push_back(mk(2'b01, 32'h00,  32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0));
        vecs.push_back(mk(2'b10, 32'h400, 32'h0,         4'h0, 32'h0, 1'b1));
        vecs.push_back(mk(2'b01, 32'h400, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1));
        vecs.push_back(mk(2'b10, 32'h00,  32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0));
        vecs.push_back(mk(2'b01, 32'h3FC, 32'h0BAD_C0DE, 4'hF, 32'h0, 1'b0));
        vecs.push_back(mk(2'b11, 32'h3FC, 32'h0,         4'h0, 32'h0BAD_C0DE, 1'b0));
        vecs.push_back(mk(2'b01, 32'h24,  32'h0000_0000, 4'hF, 32'h0, 1'b0));
`ifdef T07_MEM_RESPONDER_ALIGN_CHECK_EN
        vecs.push_back(mk(2'b01, 32'h24,  32'hAABB_CCDD, 4'hA, 32'h0, 1'b1));
        vecs.push_back(mk(2'b10, 32'h24,  32'h0,         4'h0, 32'h0000_0000, 1'b0));
        vecs.push_back(mk(2'b10, 32'h21,  32'h0,         4'h0, 32'h0, 1'b1));
`else
        vecs.push_back(mk(2'b01, 32'h24,  32'hAABB_CCDD, 4'hA, 32'h0, 1'b0));
        vecs.push_back(mk(2'b10, 32'h24,  32'h0,         4'h0, 32'hAA00_CC00, 1'b0));
        vecs.push_back(mk(2'b10, 32'h21,  32'h0,         4'h0, 32'h1122_33AB, 1'b0));
`endif
        vecs.push_back(mk(2'b01, 32'h30,  32'h1234_5678, 4'hF, 32'h0, 1'b0));

        nrst = 1'b0; rwi = 2'b00; addr_i = 32'd0; wdata_i = 32'd0; wsel_i = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        nrst = 1'b1;

        foreach (vecs[i]) req(vecs[i], 1'b0);

        // rwi dropped and address changed mid-access: captured request still served.
        req(mk(2'b10, 32'h20, 32'h0, 4'h0, 32'h1122_33AB, 1'b0), 1'b1);

        // Held request is serviced once; release and reassert gives a second pulse.
        @(negedge clk);
        rwi = 2'b10; addr_i = 32'h10;
        count_pulses(14, p);
        chk("rearm_hold_pulses", 32'(p), 32'd1);
        chk("rearm_rdata", rdata_o, 32'h0051_3093);
        rwi = 2'b00;
        @(negedge clk);
        rwi = 2'b10;
        count_pulses(8, p);
        chk("rearm_second_pulses", 32'(p), 32'd1);
        rwi = 2'b00;
        repeat (2) @(negedge clk);
        last_rd = 32'h0051_3093;

        // Reset in the middle of a write aborts it.
        rwi = 2'b01; addr_i = 32'h30; wdata_i = 32'hCAFE_F00D; wsel_i = 4'hF;
        @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        nrst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_state", 32'(state_o), 32'd0);
        chk("abort_rdata", rdata_o, 32'd0);
        rwi = 2'b00;
        @(negedge clk);
        nrst = 1'b1;
        last_rd = 32'd0;
        req(mk(2'b10, 32'h30, 32'h0, 4'h0, 32'h1234_5678, 1'b0), 1'b0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
`default_nettype wire
